wddl_key_window: RTL
====================

Name: wddl_key_window

Overview:
Dual-rail (WDDL) sliding window of the eight most recent AES-256 key-schedule words. It sits directly downstream of the 3-input dual-rail word XOR and captures each new key word that XOR produces. It also feeds back w[i-8] and w[i-1] as that XOR's operands, after the SubWord/RotWord/Rcon path for w[i-1]. The block inserts a WDDL precharge phase between every evaluation, counts the 60 expanded words, and flags dual-rail encoding violations.

Parameters:
WORD, 32, width of one key word in bits (per rail)
DEPTH, 8, window length in words (Nk for AES-256)
TOTAL, 60, number of words to produce (Nb*(Nr+1))

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new expansion (honoured only in IDLE/DONE)
in_valid  input  1  in_T/in_F hold a word (cipher key words 0..7, then XOR results 8..59)
in_T  input  WORD  true rail of incoming word
in_F  input  WORD  false rail of incoming word
in_ready  output  1  block accepts a word this cycle
wm8_T  output  WORD  true rail of w[i-8]
wm8_F  output  WORD  false rail of w[i-8]
wm1_T  output  WORD  true rail of w[i-1]
wm1_F  output  WORD  false rail of w[i-1]
out_valid  output  1  wm8/wm1 carry valid evaluated data
word_idx  output  6  index i of the next word to be captured (0..60)
done  output  1  high in DONE state (all TOTAL words captured)
rail_err  output  1  sticky: an input bit was 1/1 while in_valid was high

Behaviour:
- Single clock domain. rst_n is asynchronous active-low. On reset: state=IDLE; every output = 0; buffer = all 0/0; write pointer wp = 0.
- States: IDLE, PRE, EVAL, DONE.
  - IDLE/DONE: start=1 -> PRE; word_idx<=0; wp<=0; rail_err<=0. Buffer contents are not cleared.
  - PRE: lasts exactly 1 cycle. in_ready=0. out_valid=0. wm8/wm1 driven all-0 on both rails (WDDL precharge). Next state: EVAL.
  - EVAL: in_ready=1. A word is captured when in_valid=1 and (in_T ^ in_F) is all ones.
    - On capture: buffer[wp]<=word; wp<=(wp+1) mod DEPTH; word_idx++. Next state: PRE, or DONE if word_idx becomes TOTAL.
    - in_valid=1 with any bit 1/1: no capture; rail_err<=1 (sticky); stay in EVAL.
    - in_valid=1 with any bit 0/0 and none 1/1: treated as incomplete; no capture; no error; stay in EVAL.
- Outputs in EVAL: wm8 = buffer[wp] (oldest entry = w[i-8]); wm1 = buffer[(wp-1) mod DEPTH]. Outputs are registered, so they present the state after the last capture.
- out_valid = 1 only in EVAL with word_idx >= DEPTH. While word_idx < DEPTH (key loading), wm8/wm1 are driven 0/0 and out_valid=0.
- DONE: done=1; in_ready=0; out_valid=0; outputs precharged 0/0; word_idx holds TOTAL.
- start in PRE/EVAL is ignored.
- Pointer wraps 7->0; no overflow is possible since capture is gated by state.
- Throughput: at most one word per 2 cycles (PRE+EVAL). Latency from capture edge to a new valid window: 2 cycles.
- Reset asserted mid-expansion: immediate return to reset values; a new start is required.
- Every registered output bit pair is either 0/0 (precharge) or complementary; 1/1 is never driven.

Test Plan:
- Reset with rst_n low mid-EVAL -> all outputs 0 asynchronously, state IDLE, word_idx=0.
- start; load key words 0x00000000..0x00000007 (dual-rail complement) -> in_ready alternates 0,1; out_valid=0 until word_idx=8; then wm8=0x00000000 and wm1=0x00000007.
- Continue with XOR words 0xA5A5A5A5 (idx 8) and 0x5A5A5A5A (idx 9) -> after idx 9 captured: wm8=0x00000002, wm1=0x5A5A5A5A; wp wrapped to 2.
- Feed bit 3 as 1/1 with in_valid=1 in EVAL -> no capture, word_idx unchanged, rail_err=1 and stays 1 until the next start.
- Feed word with bit 0 as 0/0 for 3 cycles, then valid -> no capture and no error during the 0/0 cycles; capture on the 4th cycle.
- Run to 60 words -> done=1 in the cycle after the 60th capture, in_ready=0, outputs 0/0; start -> word_idx=0, PRE then EVAL.

Source files
------------

// File: rtl/wddl_key_window.sv
// wddl_key_window: dual-rail sliding window of the last DEPTH key-schedule words, with a precharge phase between evaluations.
// Ports: clk/rst_n (async active-low); start begins an expansion; in_valid/in_T/in_F carry an incoming dual-rail word;
// in_ready marks EVAL; wm8_T/F and wm1_T/F present w[i-8] and w[i-1]; out_valid qualifies them; word_idx counts
// captured words; done marks a completed expansion; rail_err is a sticky 1/1 encoding violation.
module wddl_key_window #(
  parameter int WORD  = 32,
  parameter int DEPTH = 8,
  parameter int TOTAL = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [WORD-1:0] in_T,
  input  logic [WORD-1:0] in_F,
  output logic            in_ready,
  output logic [WORD-1:0] wm8_T,
  output logic [WORD-1:0] wm8_F,
  output logic [WORD-1:0] wm1_T,
  output logic [WORD-1:0] wm1_F,
  output logic            out_valid,
  output logic [5:0]      word_idx,
  output logic            done,
  output logic            rail_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;
  state_t          state, nxt_state;
  logic [AW-1:0]   wp, nxt_wp, rp;
  logic [5:0]      nxt_idx;
  logic [WORD-1:0] buf_t [DEPTH];
  logic [WORD-1:0] buf_f [DEPTH];
  logic            go, clash, capture, win;
  always_comb begin
    go        = (state == IDLE || state == DONE) && start;
    clash     = state == EVAL && in_valid && |(in_T & in_F);
    // a word is complete only when every bit pair is complementary
    capture   = state == EVAL && in_valid && &(in_T ^ in_F);
    nxt_idx   = go ? '0 : capture ? word_idx + 6'd1 : word_idx;
    nxt_wp    = go ? '0 : capture ? (wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1)) : wp;
    nxt_state = go ? PRE
              : state == PRE ? EVAL
              : capture ? (nxt_idx == 6'(TOTAL) ? DONE : PRE)
              : state;
    rp        = wp == '0 ? AW'(DEPTH - 1) : wp - AW'(1);
    // capture always leaves EVAL, so the window is only presented when the buffer is stable
    win       = nxt_state == EVAL && nxt_idx >= 6'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wp        <= '0;
      word_idx  <= '0;
      rail_err  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      wm8_T     <= '0;
      wm8_F     <= '0;
      wm1_T     <= '0;
      wm1_F     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        buf_t[k] <= '0;
        buf_f[k] <= '0;
      end
    end else begin
      state     <= nxt_state;
      wp        <= nxt_wp;
      word_idx  <= nxt_idx;
      rail_err  <= go ? 1'b0 : (rail_err | clash);
      in_ready  <= nxt_state == EVAL;
      out_valid <= win;
      done      <= nxt_state == DONE;
      wm8_T     <= win ? buf_t[wp] : '0;
      wm8_F     <= win ? buf_f[wp] : '0;
      wm1_T     <= win ? buf_t[rp] : '0;
      wm1_F     <= win ? buf_f[rp] : '0;
      if (capture) begin
        buf_t[wp] <= in_T;
        buf_f[wp] <= in_F;
      end
    end
  end
endmodule
